lfst_table: RTL and testbench

Last Fetched Store Table for store-set memory dependence prediction in the rename stage, directly downstream of the intra-bundle store-set dependency checker. For each of the four slots in a rename bundle, it resolves the store-queue tag that the slot's load or store must wait on. The source is an earlier store in the same bundle, selected by the checker's select codes, or the 128-entry table. It then records the bundle's stores as the newest store of their store sets. Entries are retired when their store issues, and the whole table is cleared on pipeline flush.

---
 rtl/lfst_table.sv | 151 +++++++++++++++
 tb/tb_lfst_table.sv | 120 ++++++++++++
 2 files changed

// File: rtl/lfst_table.sv
// Last Fetched Store Table: resolves per-slot store-queue dependencies for a
// 4-wide rename bundle and records the bundle's stores as newest per store set.
module lfst_table #(
  parameter int SSID_W = 7,
  parameter int TAG_W  = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic              bnd_vld_i,
  input  logic [SSID_W-1:0] ssid0_i,
  input  logic [SSID_W-1:0] ssid1_i,
  input  logic [SSID_W-1:0] ssid2_i,
  input  logic [SSID_W-1:0] ssid3_i,
  input  logic              ssid0_vld_i,
  input  logic              ssid1_vld_i,
  input  logic              ssid2_vld_i,
  input  logic              ssid3_vld_i,
  input  logic              type0_i,
  input  logic              type1_i,
  input  logic              type2_i,
  input  logic              type3_i,
  input  logic [TAG_W-1:0]  stag0_i,
  input  logic [TAG_W-1:0]  stag1_i,
  input  logic [TAG_W-1:0]  stag2_i,
  input  logic [TAG_W-1:0]  stag3_i,
  input  logic              ssid1sel_i,
  input  logic [1:0]        ssid2sel_i,
  input  logic [1:0]        ssid3sel_i,
  input  logic              st_iss_vld_i,
  input  logic [SSID_W-1:0] st_iss_ssid_i,
  input  logic [TAG_W-1:0]  st_iss_tag_i,
  output logic              out_vld_o,
  output logic              dep0_vld_o,
  output logic              dep1_vld_o,
  output logic              dep2_vld_o,
  output logic              dep3_vld_o,
  output logic [TAG_W-1:0]  dep0_tag_o,
  output logic [TAG_W-1:0]  dep1_tag_o,
  output logic [TAG_W-1:0]  dep2_tag_o,
  output logic [TAG_W-1:0]  dep3_tag_o
);

  localparam int          DEPTH   = 1 << SSID_W;
  localparam int          NSLOT   = 4;
  localparam logic [1:0]  SEL_TBL = 2'b11;

  logic [SSID_W-1:0] ssid [NSLOT];
  logic [TAG_W-1:0]  stag [NSLOT];
  logic [1:0]        sel  [NSLOT];
  logic [NSLOT-1:0]  ssid_vld;
  logic [NSLOT-1:0]  is_st;
  logic              acc;

  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [TAG_W-1:0]  tag_q [DEPTH];
  logic [TAG_W-1:0]  tag_d [DEPTH];

  logic [NSLOT-1:0]  dep_vld_d, dep_vld_q;
  logic [TAG_W-1:0]  dep_tag_d [NSLOT];
  logic [TAG_W-1:0]  dep_tag_q [NSLOT];
  logic              out_vld_q;

  assign ssid[0] = ssid0_i;
  assign ssid[1] = ssid1_i;
  assign ssid[2] = ssid2_i;
  assign ssid[3] = ssid3_i;
  assign stag[0] = stag0_i;
  assign stag[1] = stag1_i;
  assign stag[2] = stag2_i;
  assign stag[3] = stag3_i;
  assign ssid_vld = {ssid3_vld_i, ssid2_vld_i, ssid1_vld_i, ssid0_vld_i};
  assign is_st    = {type3_i, type2_i, type1_i, type0_i};

  // Select codes normalised: SEL_TBL means table, otherwise the earlier slot index.
  assign sel[0] = SEL_TBL;
  assign sel[1] = ssid1sel_i    ? SEL_TBL : 2'b00;
  assign sel[2] = ssid2sel_i[1] ? SEL_TBL : ssid2sel_i;
  assign sel[3] = ssid3sel_i;

  assign acc = bnd_vld_i & ~stall_i & ~flush_i;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    dep_vld_d = '0;
    for (int n = 0; n < NSLOT; n++) begin
      dep_tag_d[n] = '0;
      if (sel[n] == SEL_TBL) begin
        dep_vld_d[n] = ssid_vld[n] & vld_q[ssid[n]] &
                       ~(st_iss_vld_i && st_iss_ssid_i == ssid[n] &&
                         st_iss_tag_i == tag_q[ssid[n]]);
        if (dep_vld_d[n]) dep_tag_d[n] = tag_q[ssid[n]];
      end else begin
        dep_vld_d[n] = 1'b1;
        dep_tag_d[n] = stag[sel[n]];
      end
    end
  end

  // Invalidate first, then writes in slot order: higher slots and writes win.
  always_comb begin
    vld_d = vld_q;
    tag_d = tag_q;
    if (st_iss_vld_i && vld_q[st_iss_ssid_i] && tag_q[st_iss_ssid_i] == st_iss_tag_i)
      vld_d[st_iss_ssid_i] = 1'b0;
    if (acc) begin
      for (int n = 0; n < NSLOT; n++) begin
        if (is_st[n] && ssid_vld[n]) begin
          vld_d[ssid[n]] = 1'b1;
          tag_d[ssid[n]] = stag[n];
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) vld_q <= '0;
    else                  vld_q <= vld_d;
  end

  // NOTE: the tag array has no reset; a tag is only read behind its vld bit.
  always_ff @(posedge clk_i) begin
    tag_q <= tag_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      out_vld_q <= 1'b0;
      dep_vld_q <= '0;
      for (int n = 0; n < NSLOT; n++) dep_tag_q[n] <= '0;
    end else if (!stall_i) begin
      out_vld_q <= bnd_vld_i;
      dep_vld_q <= bnd_vld_i ? dep_vld_d : '0;
      for (int n = 0; n < NSLOT; n++)
        dep_tag_q[n] <= bnd_vld_i ? dep_tag_d[n] : '0;
    end
  end

  assign out_vld_o  = out_vld_q;
  assign dep0_vld_o = dep_vld_q[0];
  assign dep1_vld_o = dep_vld_q[1];
  assign dep2_vld_o = dep_vld_q[2];
  assign dep3_vld_o = dep_vld_q[3];
  assign dep0_tag_o = dep_tag_q[0];
  assign dep1_tag_o = dep_tag_q[1];
  assign dep2_tag_o = dep_tag_q[2];
  assign dep3_tag_o = dep_tag_q[3];

endmodule

// File: tb/tb_lfst_table.sv
// Directed bench for lfst_table: hand-derived expected outputs go through a
// scoreboard queue and are compared one cycle after each bundle is driven.
module tb_lfst_table;

  logic       clk = 1'b0;
  logic       rst, flush, stall, bnd_vld;
  logic [6:0] ssid [4];
  logic [3:0] ssid_vld, typ;
  logic [5:0] stag [4];
  logic       sel1;
  logic [1:0] sel2, sel3;
  logic       iss_vld;
  logic [6:0] iss_ssid;
  logic [5:0] iss_tag;

  logic       out_vld, d0v, d1v, d2v, d3v;
  logic [5:0] d0t, d1t, d2t, d3t;
  logic [28:0] obs;
  logic [28:0] exp_q [$];
  logic [28:0] want;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lfst_table #(.SSID_W(7), .TAG_W(6)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .stall_i(stall), .bnd_vld_i(bnd_vld),
    .ssid0_i(ssid[0]), .ssid1_i(ssid[1]), .ssid2_i(ssid[2]), .ssid3_i(ssid[3]),
    .ssid0_vld_i(ssid_vld[0]), .ssid1_vld_i(ssid_vld[1]),
    .ssid2_vld_i(ssid_vld[2]), .ssid3_vld_i(ssid_vld[3]),
    .type0_i(typ[0]), .type1_i(typ[1]), .type2_i(typ[2]), .type3_i(typ[3]),
    .stag0_i(stag[0]), .stag1_i(stag[1]), .stag2_i(stag[2]), .stag3_i(stag[3]),
    .ssid1sel_i(sel1), .ssid2sel_i(sel2), .ssid3sel_i(sel3),
    .st_iss_vld_i(iss_vld), .st_iss_ssid_i(iss_ssid), .st_iss_tag_i(iss_tag),
    .out_vld_o(out_vld),
    .dep0_vld_o(d0v), .dep1_vld_o(d1v), .dep2_vld_o(d2v), .dep3_vld_o(d3v),
    .dep0_tag_o(d0t), .dep1_tag_o(d1t), .dep2_tag_o(d2t), .dep3_tag_o(d3t)
  );

  assign obs = {out_vld, d3v, d2v, d1v, d0v, d3t, d2t, d1t, d0t};

  function automatic logic [28:0] e(input logic ov, input logic [3:0] v,
                                    input logic [5:0] t3, t2, t1, t0);
    return {ov, v, t3, t2, t1, t0};
  endfunction

  task automatic idle();
    rst = 0; flush = 0; stall = 0; bnd_vld = 0;
    ssid_vld = '0; typ = '0;
    for (int i = 0; i < 4; i++) begin ssid[i] = '0; stag[i] = '0; end
    sel1 = 1'b1; sel2 = 2'b10; sel3 = 2'b11;
    iss_vld = 0; iss_ssid = '0; iss_tag = '0;
  endtask

  task automatic sl(input int n, input logic [6:0] s, input logic st, input logic [5:0] g);
    bnd_vld = 1; ssid[n] = s; ssid_vld[n] = 1'b1; typ[n] = st; stag[n] = g;
  endtask

  task automatic issue(input logic [6:0] s, input logic [5:0] g);
    iss_vld = 1; iss_ssid = s; iss_tag = g;
  endtask

  task automatic step(input string name, input logic [28:0] expv);
    exp_q.push_back(expv);
    @(posedge clk);
    #1;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $error("FAIL %s: scoreboard empty", name);
    end else begin
      want = exp_q.pop_front();
      assert (obs === want) else begin
        fails++;
        $error("FAIL %s: observed %h expected %h", name, obs, want);
      end
    end
    idle();
  endtask

  initial begin
    idle();
    #1;
    rst = 1;                                   step("reset", e(0, 4'b0000, 0, 0, 0, 0));
    sl(0, 5, 0, 0);                            step("first_load_miss", e(1, 4'b0000, 0, 0, 0, 0));
    sl(0, 5, 1, 12);                           step("store_s5_t12", e(1, 4'b0000, 0, 0, 0, 0));
    sl(2, 5, 0, 0);                            step("load_slot2_hit", e(1, 4'b0100, 0, 12, 0, 0));
    sl(0, 9, 1, 3); sl(1, 9, 1, 4); sl(3, 9, 0, 0); sel3 = 2'b01;
                                               step("intra_bundle_slot1", e(1, 4'b1000, 4, 0, 0, 0));
    sl(0, 9, 0, 0); sl(1, 5, 0, 0); issue(5, 11);
                                               step("slot1_wins_tagmiss_iss", e(1, 4'b0011, 0, 0, 12, 4));
    issue(5, 11);                              step("idle_no_bundle", e(0, 4'b0000, 0, 0, 0, 0));
    sl(0, 5, 0, 0); issue(5, 12);              step("same_cycle_kill", e(1, 4'b0000, 0, 0, 0, 0));
    sl(0, 5, 0, 0); sl(1, 7, 1, 2);            step("cleared_miss", e(1, 4'b0000, 0, 0, 0, 0));
    sl(0, 7, 1, 8); issue(7, 2);               step("write_vs_inval", e(1, 4'b0000, 0, 0, 0, 0));
    sl(0, 7, 0, 0);                            step("write_wins", e(1, 4'b0001, 0, 0, 0, 8));
    sl(0, 1, 1, 20); sl(1, 2, 1, 21); sl(2, 3, 1, 22);
                                               step("populate", e(1, 4'b0000, 0, 0, 0, 0));
    sl(0, 1, 0, 0); sl(1, 2, 0, 0); sl(2, 3, 0, 0); sl(3, 7, 0, 0);
                                               step("all_table_hits", e(1, 4'b1111, 8, 22, 21, 20));
    sl(0, 1, 0, 0); flush = 1;                 step("flush_drops", e(0, 4'b0000, 0, 0, 0, 0));
    sl(0, 1, 0, 0); sl(1, 2, 0, 0); sl(2, 3, 0, 0); sl(3, 7, 0, 0);
                                               step("post_flush_miss", e(1, 4'b0000, 0, 0, 0, 0));
    sl(0, 4, 1, 30);                           step("store_s4", e(1, 4'b0000, 0, 0, 0, 0));
    sl(0, 4, 0, 0);                            step("pre_stall_hit", e(1, 4'b0001, 0, 0, 0, 30));
    for (int i = 0; i < 3; i++) begin
      sl(0, 6, 1, 40); sl(1, 4, 0, 0); stall = 1;
      if (i == 1) issue(4, 30);
      step($sformatf("stall_hold%0d", i), e(1, 4'b0001, 0, 0, 0, 30));
    end
    sl(0, 6, 0, 0); sl(1, 4, 0, 0);            step("stall_no_write", e(1, 4'b0000, 0, 0, 0, 0));
    sl(0, 10, 1, 5);                           step("store_s10", e(1, 4'b0000, 0, 0, 0, 0));
    sl(0, 10, 0, 0);                           step("s10_hit", e(1, 4'b0001, 0, 0, 0, 5));
    sl(0, 10, 0, 0); stall = 1; flush = 1;     step("flush_stalled", e(0, 4'b0000, 0, 0, 0, 0));
    sl(0, 10, 0, 0);                           step("flush_stalled_miss", e(1, 4'b0000, 0, 0, 0, 0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
